// File: rtl/conversor_pkg.sv
// conversor_pkg: definitions shared by the serializador and the downstream
// conversor.
//   state_t       - frame FSM states (idle, shifting, parity bit, idle gap)
//   DEFAULT_WIDTH - default parallel word width
//   CNT_W         - bit/gap counter width (covers a 32-bit word and a 15-cycle gap)
//   to_count()    - clamps an integer load value into the counter width
package conversor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = 5;

    // Negative values collapse to 0 so that GAP=0 or N=1 still give a legal load.
    function automatic logic [CNT_W-1:0] to_count(input int value);
        return (value <= 0) ? '0 : CNT_W'(value);
    endfunction

endpackage

// File: rtl/contador_bits.sv
// contador_bits: loadable down-counter with a zero flag. The serializer uses
// one instance for both the data-bit index and the inter-frame gap count.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (count clears to 0)
//   load       - load load_val on the next rising edge (has priority)
//   load_val   - value to load
//   dec        - decrement by one; saturates at 0
//   count      - current count
//   zero       - count == 0
module contador_bits
    import conversor_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/serializador.sv
// serializador: parallel-to-serial converter, MSB first, with frame strobes.
// A word is accepted when in_valid is high while out_ready is high (IDLE
// only). The frame then occupies N data cycles, an optional even-parity
// cycle and GAP idle cycles before returning to IDLE.
// Optional feature: define SERIALIZADOR_PARITY_EN to append an even-parity
// bit after the data; out_C then marks the parity bit, not the last data bit.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   in_par     - parallel word (N bits), sampled only on the handshake edge
//   in_valid   - in_par holds a word to send
//   out_ready  - high exactly in IDLE
//   out_ser    - serial data (registered)
//   out_A      - first bit of frame strobe (registered)
//   out_B      - frame bit qualifier (registered)
//   out_C      - last bit of frame strobe (registered)
module serializador
    import conversor_pkg::*;
#(
    parameter int N   = DEFAULT_WIDTH,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_par,
    input  logic         in_valid,
    output logic         out_ready,
    output logic         out_ser,
    output logic         out_A,
    output logic         out_B,
    output logic         out_C
);

    localparam logic [CNT_W-1:0] BIT_LOAD = to_count(N - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = to_count(GAP - 1);

`ifdef SERIALIZADOR_PARITY_EN
    localparam bit DATA_ENDS_FRAME = 1'b0;
`else
    localparam bit DATA_ENDS_FRAME = 1'b1;
`endif

    state_t           state;
    logic [N-1:0]     shreg;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic [CNT_W-1:0] nxt_idx;
    logic             nxt_bit;

    contador_bits #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    assign out_ready = (state == ST_IDLE);

    // Outputs are registered, so each cycle presents the bit for the next
    // counter value; nxt_bit is the stored bit at index cnt-1.
    assign nxt_idx = cnt - 1'b1;

    always_comb begin
        nxt_bit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (nxt_idx == CNT_W'(i)) begin
                nxt_bit = shreg[i];
            end
        end
    end

    // Counter control: load the bit index on handshake, reload with the gap
    // length on entry to GAP, otherwise count down.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = BIT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (DATA_ENDS_FRAME && (GAP > 0)) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end
            end
`ifdef SERIALIZADOR_PARITY_EN
            ST_PAR: begin
                if (GAP > 0) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end
            end
`endif
            ST_GAP: begin
                cnt_dec = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            out_ser <= 1'b0;
            out_A   <= 1'b0;
            out_B   <= 1'b0;
            out_C   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state   <= ST_SHIFT;
                        shreg   <= in_par;
                        out_ser <= in_par[N-1];
                        out_A   <= 1'b1;
                        out_B   <= 1'b1;
                        out_C   <= DATA_ENDS_FRAME && (N == 1);
                    end else begin
                        out_ser <= 1'b0;
                        out_A   <= 1'b0;
                        out_B   <= 1'b0;
                        out_C   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!cnt_zero) begin
                        out_ser <= nxt_bit;
                        out_A   <= 1'b0;
                        out_B   <= 1'b1;
                        out_C   <= DATA_ENDS_FRAME && (nxt_idx == '0);
                    end else begin
`ifdef SERIALIZADOR_PARITY_EN
                        state   <= ST_PAR;
                        out_ser <= ^shreg;
                        out_A   <= 1'b0;
                        out_B   <= 1'b1;
                        out_C   <= 1'b1;
`else
                        state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                        out_ser <= 1'b0;
                        out_A   <= 1'b0;
                        out_B   <= 1'b0;
                        out_C   <= 1'b0;
`endif
                    end
                end
`ifdef SERIALIZADOR_PARITY_EN
                ST_PAR: begin
                    state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    out_ser <= 1'b0;
                    out_A   <= 1'b0;
                    out_B   <= 1'b0;
                    out_C   <= 1'b0;
                end
`endif
                ST_GAP: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                    end
                    out_ser <= 1'b0;
                    out_A   <= 1'b0;
                    out_B   <= 1'b0;
                    out_C   <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    out_ser <= 1'b0;
                    out_A   <= 1'b0;
                    out_B   <= 1'b0;
                    out_C   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador.sv
// tb_serializador: scoreboard bench for serializador (N=4, GAP=1) plus a
// second instance with N=1, GAP=0. Honours SERIALIZADOR_PARITY_EN.
module tb_serializador;

    localparam int N   = 4;
    localparam int GAP = 1;
`ifdef SERIALIZADOR_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD  = 1 + N + P + GAP;
    localparam int PERIOD1 = 1 + 1 + P + 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_par = '0;
    logic         in_valid = 1'b0;
    logic         out_ready, out_ser, out_A, out_B, out_C;

    logic [0:0]   in_par1 = '0;
    logic         in_valid1 = 1'b0;
    logic         out_ready1, out_ser1, out_A1, out_B1, out_C1;

    always #5 clk = ~clk;

    serializador #(.N(N), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .in_par(in_par), .in_valid(in_valid),
        .out_ready(out_ready), .out_ser(out_ser),
        .out_A(out_A), .out_B(out_B), .out_C(out_C)
    );

    serializador #(.N(1), .GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_par(in_par1), .in_valid(in_valid1),
        .out_ready(out_ready1), .out_ser(out_ser1),
        .out_A(out_A1), .out_B(out_B1), .out_C(out_C1)
    );

    typedef struct packed {
        logic ser;
        logic a;
        logic c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bit sequence of one frame for word w.
    task automatic push_frame(input logic [N-1:0] w);
        exp_t e;
        for (int i = N - 1; i >= 0; i--) begin
            e.ser = w[i];
            e.a   = (i == N - 1);
            e.c   = (i == 0) && (P == 0);
            q.push_back(e);
        end
        if (P == 1) begin
            e.ser = ^w;
            e.a   = 1'b0;
            e.c   = 1'b1;
            q.push_back(e);
        end
    endtask

    // Monitor: every qualified bit must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_B) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got ser=%0b A=%0b C=%0b expected no frame bit",
                             out_ser, out_A, out_C);
                end else begin
                    e = q.pop_front();
                    check1("ser", 32'(out_ser), 32'(e.ser));
                    check1("strobe_A", 32'(out_A), 32'(e.a));
                    check1("strobe_C", 32'(out_C), 32'(e.c));
                end
            end else begin
                check1("idle_strobes", {30'd0, out_A, out_C}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!out_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("ready_timeout", 32'(out_ready), 32'd1);
    endtask

    task automatic send(input logic [N-1:0] w);
        wait_ready();
        in_par   = w;
        in_valid = 1'b1;
        push_frame(w);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] words [4];
        exp_t e;
        int r_prev;
        int nready;
        int k;
        int n;
        logic [3:0] exp1;

        words[0] = 4'b0111;
        words[1] = 4'h3;
        words[2] = 4'hE;
        words[3] = 4'h8;

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_outputs", {27'd0, out_ready, out_ser, out_A, out_B, out_C}, {27'd0, 5'b10000});
        check1("rst_outputs1", {27'd0, out_ready1, out_ser1, out_A1, out_B1, out_C1}, {27'd0, 5'b10000});

        // Handshake on the very first edge after reset release: 1011
        rst_n    = 1'b1;
        in_par   = 4'b1011;
        in_valid = 1'b1;
        push_frame(4'b1011);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // in_valid during SHIFT is ignored and not queued
        @(negedge clk);
        in_par   = 4'hF;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;

        // Mid-frame change of in_par: A then 5, stream stays 1,0,1,0
        wait_ready();
        in_par   = 4'hA;
        in_valid = 1'b1;
        push_frame(4'hA);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        in_par = 4'h5;

        send(4'b0000);
        send(4'b1111);

        // Continuous in_valid: one ready cycle per frame, fixed period
        wait_ready();
        in_valid = 1'b1;
        r_prev   = -1;
        nready   = 0;
        k        = 0;
        for (int cyc = 0; cyc < 4 * PERIOD; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_ready) begin
                in_par = words[k % 4];
                push_frame(words[k % 4]);
                k++;
                nready++;
                if (r_prev >= 0) check1("frame_period", 32'(cyc - r_prev), 32'(PERIOD));
                r_prev = cyc;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check1("ready_count", 32'(nready), 32'd4);

        // Reset during the 2nd data bit of 1100: only the first bit appears
        wait_ready();
        in_par   = 4'b1100;
        in_valid = 1'b1;
        e.ser = 1'b1;
        e.a   = 1'b1;
        e.c   = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check1("abort_outputs", {27'd0, out_ready, out_ser, out_A, out_B, out_C}, {27'd0, 5'b10000});
        @(negedge clk);
        check1("abort_hold", {27'd0, out_ready, out_ser, out_A, out_B, out_C}, {27'd0, 5'b10000});
        rst_n = 1'b1;
        send(4'b1001);

        // Drain scoreboard
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("queue_drained", 32'(q.size()), 32'd0);

        // N=1, GAP=0: single-bit frames back to back
        @(negedge clk);
        in_par1   = 1'b1;
        in_valid1 = 1'b1;
        for (int j = 0; j < 3 * PERIOD1; j++) begin
            @(negedge clk);
            if ((j % PERIOD1) == 0)
                exp1 = {1'b1, 1'b1, (P == 0) ? 1'b1 : 1'b0, 1'b1};
            else if (P == 1 && (j % PERIOD1) == 1)
                exp1 = 4'b0111;
            else
                exp1 = 4'b0000;
            check1("n1_frame", {28'd0, out_A1, out_B1, out_C1, out_ser1}, {28'd0, exp1});
        end
        in_valid1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
